// File: rtl/reprodutor_sequencia.sv
// Sequence player: records up to DEPTH entries while idle, then shows each one
// for ON_CYCLES cycles with OFF_CYCLES blank cycles between entries.
module reprodutor_sequencia #(
    parameter int WIDTH      = 7,
    parameter int DEPTH      = 16,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     restart,
    input  logic                     start,
    output logic [WIDTH-1:0]         Q,
    output logic                     valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, FIM} state_t;

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic [AW-1:0]     idx_reg;
    logic [TW-1:0]     timer_reg;
    logic [WIDTH-1:0]  q_reg;
    logic              valid_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              full_int;
    logic              wr_fire;
    logic [CW-1:0]     last_idx;

    assign full_int = (count_reg == CW'(DEPTH));
    assign last_idx = count_reg - CW'(1);

    // restart and start both take priority over a write in the same cycle
    assign wr_fire = clear_n && (state_reg == IDLE) && wr_en && !full_int
                     && !restart && !start;

    // Buffer storage has no reset so contents survive clear_n and restart.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[count_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            idx_reg   <= '0;
            timer_reg <= '0;
            q_reg     <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (restart) begin
                        count_reg <= '0;
                    end else if (start) begin
                        if (count_reg != '0) begin
                            state_reg <= SHOW;
                            idx_reg   <= '0;
                            timer_reg <= '0;
                            q_reg     <= mem[AW'(0)];
                            valid_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= FIM;
                            done_reg  <= 1'b1;
                        end
                    end else if (wr_fire) begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                SHOW: begin
                    if (timer_reg == TW'(ON_CYCLES - 1)) begin
                        timer_reg <= '0;
                        q_reg     <= '0;
                        valid_reg <= 1'b0;
                        if ({1'b0, idx_reg} == last_idx) begin
                            state_reg <= FIM;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= GAP;
                        end
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                GAP: begin
                    if (timer_reg == TW'(OFF_CYCLES - 1)) begin
                        timer_reg <= '0;
                        idx_reg   <= idx_reg + AW'(1);
                        q_reg     <= mem[idx_reg + AW'(1)];
                        valid_reg <= 1'b1;
                        state_reg <= SHOW;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                FIM: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Q     = q_reg;
    assign valid = valid_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign count = count_reg;
    assign full  = full_int;

endmodule

// File: tb/tb_reprodutor_sequencia.sv
// Directed bench for reprodutor_sequencia with default parameters
// (WIDTH 7, DEPTH 16, ON 4, OFF 2).
module tb_reprodutor_sequencia;

    logic       clock;
    logic       clear_n;
    logic       wr_en;
    logic [6:0] wr_data;
    logic       restart;
    logic       start;
    logic [6:0] Q;
    logic       valid;
    logic       busy;
    logic       done;
    logic [4:0] count;
    logic       full;

    int checks;
    int failures;

    reprodutor_sequencia dut (
        .clock   (clock),
        .clear_n (clear_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .restart (restart),
        .start   (start),
        .Q       (Q),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .full    (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        wr_en   = 1'b0;
        restart = 1'b0;
        start   = 1'b0;
        tick();
        clear_n = 1'b1;
    endtask

    task automatic write_entry(input logic [6:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Expected {Q, valid, busy, done} for cycle c of a two-entry playback.
    function automatic logic [9:0] exp_two(input int c, input logic [6:0] a, input logic [6:0] b);
        if (c < 4)        return {a, 3'b110};
        else if (c < 6)   return {7'h00, 3'b010};
        else if (c < 10)  return {b, 3'b110};
        else if (c == 10) return {7'h00, 3'b001};
        else              return 10'h000;
    endfunction

    task automatic test_reset();
        clear_n = 1'b0;
        wr_en   = 1'b1;
        wr_data = 7'h5A;
        start   = 1'b1;
        restart = 1'b0;
        tick();
        tick();
        checks++;
        if ({Q, valid, busy, done, count, full} !== 15'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {Q, valid, busy, done, count, full});
        end
        wr_en = 1'b0;
        start = 1'b0;
        clear_n = 1'b1;
        tick();
        checks++;
        if ({Q, valid, busy, done, count, full} !== 15'h0) begin
            failures++;
            $display("FAIL reset_release_idle: got %h expected 0", {Q, valid, busy, done, count, full});
        end
        $display("test_reset done");
    endtask

    task automatic test_two_entries();
        int busy_cycles;
        int done_cycles;
        logic [9:0] e;
        do_reset();
        write_entry(7'h12);
        write_entry(7'h34);
        checks++;
        if (count !== 5'd2) begin
            failures++;
            $display("FAIL two_count: got %0d expected 2", count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        done_cycles = 0;
        for (int c = 0; c < 12; c++) begin
            e = exp_two(c, 7'h12, 7'h34);
            checks++;
            if ({Q, valid, busy, done} !== e) begin
                failures++;
                $display("FAIL two_seq cycle %0d: got Q=%h v=%b b=%b d=%b expected %h", c, Q, valid, busy, done, e);
            end
            if (busy) busy_cycles++;
            if (done) done_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != 10 || done_cycles != 1) begin
            failures++;
            $display("FAIL two_lengths: got busy=%0d done=%0d expected busy=10 done=1", busy_cycles, done_cycles);
        end
        $display("test_two_entries done");
    endtask

    task automatic test_full();
        int   n;
        int   busy_cycles;
        logic prev_valid;
        logic seen_done;
        do_reset();
        for (int i = 1; i <= 16; i++) write_entry(7'(i));
        checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            failures++;
            $display("FAIL full_after_16: got count=%0d full=%b expected 16 1", count, full);
        end
        write_entry(7'h7F);
        checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            failures++;
            $display("FAIL full_after_17: got count=%0d full=%b expected 16 1", count, full);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        busy_cycles = 0;
        prev_valid = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (valid && !prev_valid) begin
                checks++;
                if (Q !== 7'(n + 1)) begin
                    failures++;
                    $display("FAIL full_entry %0d: got %h expected %h", n, Q, 7'(n + 1));
                end
                n++;
            end
            if (busy) busy_cycles++;
            prev_valid = valid;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (n != 16 || !seen_done || busy_cycles != 94) begin
            failures++;
            $display("FAIL full_playback: got entries=%0d done=%b busy=%0d expected 16 1 94", n, seen_done, busy_cycles);
        end
        $display("test_full done");
    endtask

    task automatic test_empty_start();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL empty_start: got done=%b valid=%b busy=%b expected 1 0 0", done, valid, busy);
        end
        tick();
        checks++;
        if ({done, valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL empty_after: got done=%b valid=%b busy=%b expected 0 0 0", done, valid, busy);
        end
        $display("test_empty_start done");
    endtask

    task automatic test_priority();
        do_reset();
        write_entry(7'h55);
        write_entry(7'h66);
        restart = 1'b1;
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 7'h77;
        tick();
        restart = 1'b0;
        start   = 1'b0;
        wr_en   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({count, valid, busy, done} !== 8'h00) begin
                failures++;
                $display("FAIL priority_idle cycle %0d: got count=%0d v=%b b=%b d=%b expected 0 0 0 0", c, count, valid, busy, done);
            end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL priority_start: got done=%b valid=%b busy=%b expected 1 0 0", done, valid, busy);
        end
        $display("test_priority done");
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        do_reset();
        write_entry(7'h0A);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 7'h0B;
        tick();
        for (int c = 0; c < 7; c++) begin
            if (c < 4)       e = {7'h0A, 3'b110};
            else if (c == 4) e = {7'h00, 3'b001};
            else if (c == 5) e = 10'h000;
            else             e = {7'h0A, 3'b110};
            checks++;
            if ({Q, valid, busy, done} !== e) begin
                failures++;
                $display("FAIL b2b_seq cycle %0d: got Q=%h v=%b b=%b d=%b expected %h", c, Q, valid, busy, done, e);
            end
            tick();
        end
        start = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd1) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 1", count);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_abort();
        do_reset();
        write_entry(7'h21);
        write_entry(7'h22);
        write_entry(7'h23);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if ({Q, valid, busy} !== {7'h22, 2'b11}) begin
            failures++;
            $display("FAIL abort_second_show: got Q=%h v=%b b=%b expected 22 1 1", Q, valid, busy);
        end
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        checks++;
        if ({Q, valid, busy, done, count, full} !== 15'h0) begin
            failures++;
            $display("FAIL abort_idle: got %h expected 0", {Q, valid, busy, done, count, full});
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done || busy || valid) begin
                checks++;
                failures++;
                $display("FAIL abort_quiet cycle %0d: got d=%b b=%b v=%b expected 0 0 0", c, done, busy, valid);
            end
        end
        $display("test_reset_abort done");
    endtask

    task automatic test_ignore();
        logic [9:0] e;
        do_reset();
        write_entry(7'h31);
        write_entry(7'h32);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            e = exp_two(c, 7'h31, 7'h32);
            checks++;
            if ({Q, valid, busy, done} !== e) begin
                failures++;
                $display("FAIL ignore_seq cycle %0d: got Q=%h v=%b b=%b d=%b expected %h", c, Q, valid, busy, done, e);
            end
            wr_en   = (c < 4);
            wr_data = 7'h3F;
            start   = (c == 4);
            tick();
        end
        wr_en = 1'b0;
        start = 1'b0;
        checks++;
        if (count !== 5'd2) begin
            failures++;
            $display("FAIL ignore_count: got %0d expected 2", count);
        end
        $display("test_ignore done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_n  = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        restart  = 1'b0;
        start    = 1'b0;
        test_reset();
        test_two_entries();
        test_full();
        test_empty_start();
        test_priority();
        test_back_to_back();
        test_reset_abort();
        test_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
